// File: rtl/arm_mem_bridge_if.sv
// Memory-stage bus between the pipelined core and the data-side bridge,
// plus the posted-write peripheral handshake that the bridge drives.
interface arm_mem_bridge_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pb_valid;
    logic        pb_ready;
    logic [7:0]  pb_addr;
    logic [31:0] pb_data;
    logic        irq;

    modport master (
        output mem_we, mem_addr, mem_wdata, pb_ready,
        input  mem_rdata, pb_valid, pb_addr, pb_data, irq
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, pb_ready,
        output mem_rdata, pb_valid, pb_addr, pb_data, irq
    );
endinterface

// File: rtl/arm_mem_bridge.sv
// Data-side memory for the core's M stage: zero-wait local RAM plus a posted-write FIFO toward a peripheral bus.
// Define MEM_BRIDGE_IRQ_EN to enable the low-water interrupt and its IRQMASK register at offset 0x10C.
module arm_mem_bridge #(
    parameter int RAM_AW    = 6,
    parameter int FIFO_AW   = 2,
    parameter int LOW_WATER = 1
) (
    input logic             clk,
    input logic             reset,
    arm_mem_bridge_if.slave bus
);

    localparam int RAM_DEPTH  = 1 << RAM_AW;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [31:0]        ram_q      [RAM_DEPTH];
    logic [7:0]         fifoAddr_q [FIFO_DEPTH];
    logic [31:0]        fifoData_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rdPtr_q, rdPtr_d;
    logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [15:0]        dropCnt_q, dropCnt_d;

    logic [11:0]       offset;
    logic [RAM_AW-1:0] ramIdx;
    logic isRam, isPer, isData, isStatus, isDrops, isClear, isMask;
    logic empty, full, pop, pushReq, push, drop, clearReq;
    logic unusedAddrBits;

    // Address decode; bits [15:12] and [1:0] never select anything
    assign offset   = bus.mem_addr[11:0];
    assign ramIdx   = bus.mem_addr[RAM_AW+1:2];
    assign isRam    = (bus.mem_addr[31:16] == 16'h0000);
    assign isPer    = (bus.mem_addr[31:16] == 16'h0001);
    assign isData   = isPer && (offset[11:8] == 4'h0);
    assign isStatus = isPer && (offset[11:2] == 10'h040);
    assign isDrops  = isPer && (offset[11:2] == 10'h041);
    assign isClear  = isPer && (offset[11:2] == 10'h042);
    assign isMask   = isPer && (offset[11:2] == 10'h043);
    assign unusedAddrBits = ^{bus.mem_addr[15:12], bus.mem_addr[1:0]};

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop      = !empty && bus.pb_ready;
    assign pushReq  = bus.mem_we && isData;
    assign push     = pushReq && (!full || pop);
    assign drop     = pushReq && full && !pop;
    assign clearReq = bus.mem_we && isClear;

    // FIFO bookkeeping; a full FIFO that pops and pushes together keeps its count
    always_comb begin
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        dropCnt_d = dropCnt_q;
        if (clearReq) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            dropCnt_d = '0;
        end else begin
            if (pop)
                rdPtr_d = rdPtr_q + 1'b1;
            if (push)
                wrPtr_d = wrPtr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
            if (drop && (dropCnt_q != 16'hFFFF))
                dropCnt_d = dropCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            dropCnt_q <= '0;
        end else begin
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    // Storage arrays carry no reset so they map onto plain RAM
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= bus.mem_addr[9:2];
            fifoData_q[wrPtr_q] <= bus.mem_wdata;
        end
        if (bus.mem_we && isRam)
            ram_q[ramIdx] <= bus.mem_wdata;
    end

    assign bus.pb_valid = !empty;
    assign bus.pb_addr  = fifoAddr_q[rdPtr_q];
    assign bus.pb_data  = fifoData_q[rdPtr_q];

`ifdef MEM_BRIDGE_IRQ_EN
    localparam logic [FIFO_AW:0] LOW_WATER_CNT = (FIFO_AW + 1)'(LOW_WATER);

    logic irqReg_q, irqReg_d;
    logic mask_q, mask_d;
    logic pushed_q, pushed_d;

    // irq only arms once something has been pushed since reset or CLEAR
    always_comb begin
        pushed_d = pushed_q || push;
        irqReg_d = pushed_d && (count_d <= LOW_WATER_CNT);
        mask_d   = (bus.mem_we && isMask) ? bus.mem_wdata[0] : mask_q;
        if (clearReq) begin
            pushed_d = 1'b0;
            irqReg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqReg_q <= 1'b0;
            mask_q   <= 1'b0;
            pushed_q <= 1'b0;
        end else begin
            irqReg_q <= irqReg_d;
            mask_q   <= mask_d;
            pushed_q <= pushed_d;
        end
    end

    assign bus.irq = irqReg_q && mask_q;
`else
    logic unusedLowWater;

    assign unusedLowWater = (LOW_WATER != 0);
    assign bus.irq        = 1'b0;
`endif

    // Load path is purely combinational so the core never stalls on memory
    always_comb begin
        bus.mem_rdata = 32'h0;
        if (isRam)
            bus.mem_rdata = ram_q[ramIdx];
        else if (isStatus)
            bus.mem_rdata = {16'h0, dropCnt_q[7:0], 3'b000, full, empty, 3'(count_q)};
        else if (isDrops)
            bus.mem_rdata = {16'h0, dropCnt_q};
`ifdef MEM_BRIDGE_IRQ_EN
        else if (isMask)
            bus.mem_rdata = {31'h0, mask_q};
`endif
    end

endmodule
